// File: rtl/wb_mem_responder_if.sv
// Purpose : Wishbone B3 classic/burst signal bundle between one 32-bit master and wb_mem_responder.
// Latency : n/a (wires only).
// Backpressure: master throttles with wb_stb_i; slave paces beats with wb_ack_o/wb_err_o.
//
// Ports (signals): wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[31:0], wb_sel_i[3:0], wb_dat_i[31:0],
//   wb_cti_i[2:0], wb_bte_i[1:0] (master -> slave); wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o[31:0]
//   (slave -> master). Suffixes are from the responder's point of view.
interface wb_mem_responder_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;
   logic [31:0] wb_dat_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
      output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
      input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
   );
endinterface

// File: rtl/wb_mem_responder.sv
// Purpose : Wishbone B3 memory responder (single cycles + incrementing linear/wrap4/8/16 bursts).
// Latency : first ack 1+WAIT_STATES cycles after the request is sampled, then one beat per cycle.
// Backpressure: stb low stalls a burst (no ack, pointer/data hold); cyc low abandons it.
//
// Ports: clk, rst_n (async active-low), wb (wb_mem_responder_if.slave), busy_o (not IDLE).
// Option: define WBS_RANGE_ERR_EN to terminate requests outside the RAM window with wb_err_o;
//         without it addresses alias modulo the window and wb_err_o is tied low.
module wb_mem_responder #(
   parameter int          AW          = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_mem_responder_if.slave wb,
   output logic              busy_o
);
   localparam int DEPTH = 2**AW;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   state_t        state;
   logic          ack_r;
   logic          err_r;
   logic          oob_r;     // request was out of range; every beat of it errs
   logic          we_r;      // direction latched at request, later wb_we_i ignored
   logic [3:0]    cnt;
   logic [AW-1:0] ptr;
   logic [31:0]   dat_r;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   adr_off;
   logic [AW-1:0] req_idx;
   logic [AW-1:0] wrap_mask;
   logic [AW-1:0] ptr_inc;
   logic [AW-1:0] nptr;
   logic          req;
   logic          beat;
   logic          req_err;
   logic          unused_bits;

   assign adr_off = wb.wb_adr_i - BASE_ADDR;
   assign req_idx = adr_off[AW+1:2];
   assign req     = wb.wb_cyc_i & wb.wb_stb_i;
   assign beat    = (ack_r | err_r) & req;

`ifdef WBS_RANGE_ERR_EN
   // BASE_ADDR is window aligned, so any offset bit above the window means out of range
   // (addresses below the base wrap to large offsets and are caught too).
   assign req_err   = (adr_off >> (AW + 2)) != 32'd0;
   assign wb.wb_err_o = err_r & req;
`else
   assign req_err   = 1'b0;
   assign wb.wb_err_o = 1'b0;
`endif

   assign wb.wb_ack_o = ack_r & req;
   assign wb.wb_rty_o = 1'b0;
   assign wb.wb_dat_o = dat_r;
   assign busy_o      = (state != IDLE);
   assign unused_bits = ^{adr_off[1:0], adr_off[31:AW+2]};

   // Burst address step: only the low log2(N) bits count for wrapN, linear uses all bits.
   always_comb begin
      case (wb.wb_bte_i)
         2'b01:   wrap_mask = AW'(3);
         2'b10:   wrap_mask = AW'(7);
         2'b11:   wrap_mask = AW'(15);
         default: wrap_mask = '1;
      endcase
   end

   assign ptr_inc = ptr + AW'(1);
   assign nptr    = (ptr & ~wrap_mask) | (ptr_inc & wrap_mask);

   // RAM contents survive reset; only acked in-range write beats modify them.
   always_ff @(posedge clk) begin
      if (beat && we_r && !err_r) begin
         for (int i = 0; i < 4; i++) begin
            if (wb.wb_sel_i[i]) begin
               mem[ptr][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
            end
         end
      end
   end

   // Read data is fetched on the edge that enters ACK and on every consumed burst beat
   // (from the next pointer), so wb_dat_o is already valid in the cycle its ack is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ack_r <= 1'b0;
         err_r <= 1'b0;
         oob_r <= 1'b0;
         we_r  <= 1'b0;
         cnt   <= 4'd0;
         ptr   <= '0;
         dat_r <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  ptr   <= req_idx;
                  cnt   <= 4'(WAIT_STATES);
                  we_r  <= wb.wb_we_i;
                  oob_r <= req_err;
                  if (WAIT_STATES == 0) begin
                     state <= ACK;
                     ack_r <= !req_err;
                     err_r <= req_err;
                     if (req_err) begin
                        dat_r <= 32'h0;
                     end else if (!wb.wb_we_i) begin
                        dat_r <= mem[req_idx];
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!wb.wb_cyc_i) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state <= ACK;
                     ack_r <= !oob_r;
                     err_r <= oob_r;
                     if (oob_r) begin
                        dat_r <= 32'h0;
                     end else if (!we_r) begin
                        dat_r <= mem[ptr];
                     end
                  end
               end
            end
            ACK, BURST: begin
               if (!wb.wb_cyc_i) begin
                  state <= IDLE;
                  ack_r <= 1'b0;
                  err_r <= 1'b0;
               end else if (beat) begin
                  if (wb.wb_cti_i == 3'b010) begin
                     state <= BURST;
                     ptr   <= nptr;
                     if (!we_r && !oob_r) begin
                        dat_r <= mem[nptr];
                     end
                  end else begin
                     state <= IDLE;
                     ack_r <= 1'b0;
                     err_r <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
